// File: rtl/mux_cfg_loader_pkg.sv
// Purpose : shared frame layout, command codes and FSM states for the pin-mux config loader.
// Latency : n/a (types and constants only).
// Backpress: n/a.
package mux_cfg_loader_pkg;

    localparam int FRAME_W = 16;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 6;
    localparam int SRC_W   = 8;

    // Tag in the top two bits of a read response, so the host can tell
    // a real response from the all-zero "nothing pending" pattern.
    localparam logic [1:0] READ_TAG = 2'b10;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_APPLY = 2'b11
    } cmd_e;

    typedef struct packed {
        cmd_e             cmd;
        logic [IDX_W-1:0] idx;
        logic [SRC_W-1:0] src;
    } frame_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_EXEC,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/mux_cfg_loader_sync_2ff.sv
// Purpose : two-flop synchronizer for one async level into clk.
// Latency : 2 clk.
// Backpress: none; free-running.
// Ports   : clk, rst_n (async active-low), i_d (async input), o_q (synchronized output).
module mux_cfg_loader_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mux_cfg_loader.sv
// Purpose : SPI mode-0 writer for the pin-mux selector table; shadow writes, atomic APPLY, shadow readback.
// Latency : 16th synced sck rise at T -> EXEC at T+1 -> table/flag/apply_pulse effects visible at T+2.
// Backpress: none; host must keep sck high/low >= 3 clk; edges after 16 bits are ignored until cs_n rises.
// Ports   : clk, rst_n; cfg_sck/cfg_cs_n/cfg_mosi (async SPI in), cfg_miso (registered SPI out);
//           sel_flat (active table, entry i at [i*SEL_W +: SEL_W]), apply_pulse, err_range, err_abort (sticky).
module mux_cfg_loader
    import mux_cfg_loader_pkg::*;
#(
    parameter int N_OUT = 16,
    parameter int SEL_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_sck,
    input  logic                   cfg_cs_n,
    input  logic                   cfg_mosi,
    output logic                   cfg_miso,
    output logic [N_OUT*SEL_W-1:0] sel_flat,
    output logic                   apply_pulse,
    output logic                   err_range,
    output logic                   err_abort
);

    // ---------------- synchronizers and edge detect ----------------
    logic w_sck_s, w_cs_n_s, w_mosi_s;
    logic r_sck_d, r_cs_n_d;

    mux_cfg_loader_sync_2ff #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst_n(rst_n), .i_d(cfg_sck),  .o_q(w_sck_s));
    mux_cfg_loader_sync_2ff #(.RST_VAL(1'b1)) u_sync_cs_n (.clk(clk), .rst_n(rst_n), .i_d(cfg_cs_n), .o_q(w_cs_n_s));
    mux_cfg_loader_sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .i_d(cfg_mosi), .o_q(w_mosi_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_d  <= 1'b0;
            r_cs_n_d <= 1'b1;
        end else begin
            r_sck_d  <= w_sck_s;
            r_cs_n_d <= w_cs_n_s;
        end
    end

    logic w_sck_rise, w_sck_fall, w_cs_fall;
    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s & r_sck_d;
    assign w_cs_fall  = ~w_cs_n_s & r_cs_n_d;

    // ---------------- frame FSM ----------------
    state_e               r_state, w_state_nxt;
    logic                 w_start, w_shift_en, w_exec, w_abort;
    logic [FRAME_W-1:0]   r_shift_in;
    logic [CNT_W-1:0]     r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Exits from SHIFT/DRAIN use the cs_n level rather than its edge, so a
    // cs_n rise that lands during EXEC is still honoured one cycle later.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift_en  = 1'b0;
        w_exec      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_start     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_cs_n_s) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = (r_cnt != '0);
                end else if (w_sck_rise) begin
                    w_shift_en = 1'b1;
                    if (r_cnt == CNT_W'(FRAME_W - 1)) begin
                        w_state_nxt = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_cs_n_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_in <= '0;
            r_cnt      <= '0;
        end else if (w_start) begin
            r_shift_in <= '0;
            r_cnt      <= '0;
        end else if (w_shift_en) begin
            r_shift_in <= {r_shift_in[FRAME_W-2:0], w_mosi_s};
            r_cnt      <= r_cnt + 1'b1;
        end
    end

    // ---------------- decode ----------------
    frame_t           w_frm;
    logic             w_idx_ok, w_src_ok;
    logic [SRC_W-1:0] w_rd_data;
    logic             w_wr_err, w_rd_err, w_clr_err;

    assign w_frm    = frame_t'(r_shift_in);
    assign w_idx_ok = ({1'b0, w_frm.idx} < 7'(N_OUT));
    assign w_src_ok = ((w_frm.src >> SEL_W) == '0);

    assign w_wr_err  = w_exec && (w_frm.cmd == CMD_WRITE) && !(w_idx_ok && w_src_ok);
    assign w_rd_err  = w_exec && (w_frm.cmd == CMD_READ) && !w_idx_ok;
    assign w_clr_err = w_exec && (w_frm.cmd == CMD_NOP) && w_frm.src[0];

    logic [SEL_W-1:0] r_shadow [N_OUT];
    logic [SEL_W-1:0] r_active [N_OUT];

    // Out-of-range index matches no entry, so readback data falls to zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (w_frm.idx == IDX_W'(i)) begin
                w_rd_data = SRC_W'(r_shadow[i]);
            end
        end
    end

    // ---------------- tables ----------------
    logic r_apply_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OUT; i++) begin
                r_shadow[i] <= SEL_W'(i);
                r_active[i] <= SEL_W'(i);
            end
            r_apply_pulse <= 1'b0;
        end else begin
            r_apply_pulse <= 1'b0;
            if (w_exec && (w_frm.cmd == CMD_WRITE) && w_idx_ok && w_src_ok) begin
                for (int i = 0; i < N_OUT; i++) begin
                    if (w_frm.idx == IDX_W'(i)) begin
                        r_shadow[i] <= w_frm.src[SEL_W-1:0];
                    end
                end
            end
            if (w_exec && (w_frm.cmd == CMD_APPLY)) begin
                for (int i = 0; i < N_OUT; i++) begin
                    r_active[i] <= r_shadow[i];
                end
                r_apply_pulse <= 1'b1;
            end
        end
    end

    // ---------------- sticky errors ----------------
    logic r_err_range, r_err_abort;

    // Set terms come after the clear so a new error in the same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_range <= 1'b0;
            r_err_abort <= 1'b0;
        end else begin
            if (w_clr_err) begin
                r_err_range <= 1'b0;
                r_err_abort <= 1'b0;
            end
            if (w_wr_err || w_rd_err) begin
                r_err_range <= 1'b1;
            end
            if (w_abort) begin
                r_err_abort <= 1'b1;
            end
        end
    end

    // ---------------- readback ----------------
    logic [FRAME_W-1:0] r_rsp, r_shift_out;
    logic               r_rsp_vld, r_miso;

    // A frame start always consumes the pending response; its MSB goes out
    // immediately and the remainder follows one bit per synced sck fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp       <= '0;
            r_rsp_vld   <= 1'b0;
            r_shift_out <= '0;
            r_miso      <= 1'b0;
        end else begin
            if (w_cs_n_s) begin
                r_miso <= 1'b0;
            end else if (w_start) begin
                r_miso      <= r_rsp_vld ? r_rsp[FRAME_W-1] : 1'b0;
                r_shift_out <= r_rsp_vld ? {r_rsp[FRAME_W-2:0], 1'b0} : '0;
                r_rsp_vld   <= 1'b0;
            end else if (w_sck_fall && (r_state != ST_IDLE)) begin
                r_miso      <= r_shift_out[FRAME_W-1];
                r_shift_out <= {r_shift_out[FRAME_W-2:0], 1'b0};
            end
            if (w_exec && (w_frm.cmd == CMD_READ)) begin
                r_rsp     <= {READ_TAG, w_frm.idx, w_rd_data};
                r_rsp_vld <= 1'b1;
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        sel_flat = '0;
        for (int i = 0; i < N_OUT; i++) begin
            sel_flat[i*SEL_W +: SEL_W] = r_active[i];
        end
    end

    assign cfg_miso    = r_miso;
    assign apply_pulse = r_apply_pulse;
    assign err_range   = r_err_range;
    assign err_abort   = r_err_abort;

endmodule
